input_skew_feeder: RTL and testbench

- Sits directly downstream of the activation fetch stage, between the activation SRAM read port and the west edge of the systolic array.
- Aligns SRAM read data to the fetch-stage address strobe, accounting for SRAM read latency.
- Skews each lane diagonally: lane i is delayed i extra cycles, so operands enter the array wavefront-aligned.
- Tracks vectors streamed and drains the skew pipeline after the last vector, then pulses done.

---
 rtl/input_skew_feeder_pkg.sv | 15 +
 rtl/input_skew_feeder_skew_delay_line.sv | 39 +++
 rtl/input_skew_feeder.sv | 145 ++++++++++++++
 tb/tb_input_skew_feeder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/input_skew_feeder_pkg.sv
// Shared definitions for the input skew feeder: default geometry and FSM state encoding.
package input_skew_feeder_pkg;

    localparam int unsigned SKEW_LANES     = 8;
    localparam int unsigned SKEW_DATA_BITS = 8;
    localparam int unsigned SRAM_RD_LAT    = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } feed_state_t;

endpackage

// File: rtl/input_skew_feeder_skew_delay_line.sv
// Per-lane skew register: one capture stage plus DEPTH extra stages of data and valid.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic [WIDTH-1:0] data_q [DEPTH+1];
    logic [DEPTH:0]   valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k <= DEPTH; k++) data_q[k] <= '0;
            valid_q <= '0;
        end else if (clear) begin
            for (int unsigned k = 0; k <= DEPTH; k++) data_q[k] <= '0;
            valid_q <= '0;
        end else begin
            // Bubbles are zeroed at capture so later stages never carry stale words.
            data_q[0]  <= in_valid ? in_data : '0;
            valid_q[0] <= in_valid;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign out_data  = data_q[DEPTH];
    assign out_valid = valid_q[DEPTH];

endmodule

// File: rtl/input_skew_feeder.sv
// Aligns SRAM read data to the fetch strobe and skews lane i by i cycles into the array.
// Optional SKEW_OUTPUT_REG_EN adds one output register stage (done delayed to match).
module input_skew_feeder
    import input_skew_feeder_pkg::*;
#(
    parameter int unsigned LANES     = SKEW_LANES,
    parameter int unsigned DATA_BITS = SKEW_DATA_BITS,
    parameter int unsigned SRAM_LAT  = SRAM_RD_LAT,
    parameter int unsigned CNT_BITS  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       issue,
    input  logic                       last_issue,
    input  logic [LANES*DATA_BITS-1:0] sram_rdata,
    output logic [LANES*DATA_BITS-1:0] array_data,
    output logic [LANES-1:0]           array_valid,
    output logic [CNT_BITS-1:0]        vec_count,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned DW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [SRAM_LAT-1:0]        iss_pipe;
    logic [SRAM_LAT-1:0]        last_pipe;
    logic                       rd_v;
    logic                       rd_last;
    logic [LANES*DATA_BITS-1:0] lane_data;
    logic [LANES-1:0]           lane_valid;
    feed_state_t                state;
    logic [DW-1:0]              drain_cnt;
    logic                       done_fsm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_pipe  <= '0;
            last_pipe <= '0;
        end else if (start) begin
            iss_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            iss_pipe[0]  <= issue;
            last_pipe[0] <= issue & last_issue;
            for (int unsigned k = 1; k < SRAM_LAT; k++) begin
                iss_pipe[k]  <= iss_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
            end
        end
    end

    assign rd_v    = iss_pipe[SRAM_LAT-1];
    assign rd_last = last_pipe[SRAM_LAT-1];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH (i),
            .WIDTH (DATA_BITS)
        ) u_line (
            .clk       (clk),
            .rst       (rst),
            .clear     (start),
            .in_data   (sram_rdata[i*DATA_BITS +: DATA_BITS]),
            .in_valid  (rd_v),
            .out_data  (lane_data[i*DATA_BITS +: DATA_BITS]),
            .out_valid (lane_valid[i])
        );
    end

`ifdef SKEW_OUTPUT_REG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            array_data  <= '0;
            array_valid <= '0;
            done        <= 1'b0;
        end else if (start) begin
            array_data  <= '0;
            array_valid <= '0;
            done        <= 1'b0;
        end else begin
            array_data  <= lane_data;
            array_valid <= lane_valid;
            done        <= done_fsm;
        end
    end
`else
    assign array_data  = lane_data;
    assign array_valid = lane_valid;
    assign done        = done_fsm;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec_count <= '0;
        end else if (start) begin
            vec_count <= '0;
        end else if (array_valid[0] && (vec_count != '1)) begin
            vec_count <= vec_count + CNT_BITS'(1);
        end
    end

    // A single-vector tile sees rd_v and rd_last together while IDLE, so it
    // jumps straight to the drain to keep done aligned with the last lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done_fsm  <= 1'b0;
        end else if (start) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done_fsm  <= 1'b0;
        end else begin
            done_fsm <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (rd_v && rd_last) begin
                        if (LANES == 1) begin
                            state    <= DONE;
                            done_fsm <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(LANES - 1);
                        end
                    end else if (rd_v) begin
                        state <= STREAM;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - DW'(1);
                    if (drain_cnt == DW'(1)) begin
                        state    <= DONE;
                        done_fsm <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == STREAM) || (state == DRAIN);

endmodule

// File: tb/tb_input_skew_feeder.sv
// Scoreboard bench for input_skew_feeder (LANES=4, SRAM_LAT=1): per-lane expected arrival queues.
module tb_input_skew_feeder;

    localparam int LANES = 4;
    localparam int DB    = 8;
    localparam int LAT   = 1;
    localparam int W     = LANES * DB;
`ifdef SKEW_OUTPUT_REG_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          issue = 1'b0;
    logic          last_issue = 1'b0;
    logic [W-1:0]  sram_rdata = '0;
    logic [W-1:0]  array_data;
    logic [LANES-1:0] array_valid;
    logic [7:0]    vec_count;
    logic          busy;
    logic          done;

    input_skew_feeder #(
        .LANES     (LANES),
        .DATA_BITS (DB),
        .SRAM_LAT  (LAT),
        .CNT_BITS  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .issue       (issue),
        .last_issue  (last_issue),
        .sram_rdata  (sram_rdata),
        .array_data  (array_data),
        .array_valid (array_valid),
        .vec_count   (vec_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [31:0] t;
        logic [7:0]  d;
    } ent_t;

    ent_t        lq [LANES][$];
    int          dq [$];
    logic [W-1:0] sched [int];
    int          model_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic flush_model();
        for (int i = 0; i < LANES; i++) lq[i].delete();
        dq.delete();
        model_cnt = 0;
    endtask

    // Monitor: compares every cycle against the expected arrival schedule.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_valid", array_valid, 0);
            check("rst_data", array_data, 0);
            check("rst_done", done, 0);
            check("rst_busy", busy, 0);
            check("rst_cnt", vec_count, 0);
            flush_model();
        end else begin
            for (int i = 0; i < LANES; i++) begin
                logic       ev;
                logic [7:0] ed;
                ev = (lq[i].size() > 0) && (lq[i][0].t == 32'(cyc));
                ed = ev ? lq[i][0].d : 8'h00;
                check($sformatf("lane%0d_valid", i), array_valid[i], ev);
                check($sformatf("lane%0d_data", i), array_data[i*DB +: DB], ed);
                if (ev) begin
                    void'(lq[i].pop_front());
                    if (i == 0 && model_cnt < 255) model_cnt++;
                end
            end
            begin
                logic ed;
                ed = (dq.size() > 0) && (dq[0] == cyc);
                check("done", done, ed);
                if (ed) void'(dq.pop_front());
            end
            if (start) flush_model();
        end
    end

    task automatic drive(input bit iss, input bit lst, input bit st, input logic [W-1:0] w);
        @(posedge clk);
        #1;
        issue      = iss;
        last_issue = lst;
        start      = st;
        if (sched.exists(cyc)) begin
            sram_rdata = sched[cyc];
            sched.delete(cyc);
        end else begin
            sram_rdata = W'($urandom);
        end
        if (iss && !st) begin
            sched[cyc + LAT] = w;
            for (int i = 0; i < LANES; i++)
                lq[i].push_back('{t: 32'(cyc + LAT + 1 + i + XTRA), d: w[i*DB +: DB]});
            if (lst) dq.push_back(cyc + LAT + LANES + XTRA);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, '0);
    endtask

    task automatic end_check();
        idle(LANES + LAT + 4);
        check("vec_count", vec_count, model_cnt);
        check("busy_idle", busy, 0);
        check("lanes_drained", lq[LANES-1].size(), 0);
        check("done_drained", dq.size(), 0);
    endtask

    task automatic tile(input int n, input int gap_pct);
        int k;
        k = 0;
        while (k < n) begin
            if ($urandom_range(99) < gap_pct) begin
                drive(0, 0, 0, '0);
            end else begin
                drive(1, k == n - 1, 0, W'($urandom));
                k++;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(3);

        // single vector
        drive(1, 1, 0, 32'h04030201);
        end_check();

        // back-to-back six vectors
        tile(6, 0);
        end_check();

        // bubbles: issue, gap, issue, issue(last)
        drive(1, 0, 0, W'($urandom));
        drive(0, 0, 0, '0);
        drive(1, 0, 0, W'($urandom));
        drive(1, 1, 0, W'($urandom));
        end_check();

        // start mid-stream with a coincident issue that must be ignored
        for (int k = 0; k < 3; k++) drive(1, 0, 0, W'($urandom));
        drive(1, 0, 1, W'($urandom));
        idle(2);
        check("start_busy", busy, 0);
        end_check();
        drive(1, 1, 0, 32'h08070605);
        end_check();

        // asynchronous reset mid-tile
        for (int k = 0; k < 4; k++) drive(1, 0, 0, W'($urandom));
        @(posedge clk);
        #1;
        issue = 1'b0;
        last_issue = 1'b0;
        rst = 1'b0;
        #2;
        check("async_valid", array_valid, 0);
        check("async_data", array_data, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        sched.delete();
        end_check();
        drive(1, 1, 0, 32'hA1B2C3D4);
        end_check();

        // randomized tiles
        for (int r = 0; r < 20; r++) begin
            tile($urandom_range(8, 1), $urandom_range(40));
            end_check();
        end

        // counter saturation
        tile(260, 0);
        end_check();
        check("vec_sat", vec_count, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
